// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   WIDTH-bit ripple-carry adder split into STAGES equal slices of
//   W = WIDTH/STAGES bits. Each slice owns one register stage. The carry
//   ripples from slice to slice through the stage registers, and the
//   operand slices that are not yet consumed travel alongside as skew
//   registers. A single global advance enable shifts the whole pipe, which
//   gives full valid/ready backpressure with no internal FSM.
//
// Parameters:
//   WIDTH   operand/sum width in bits (>= 1)
//   STAGES  number of pipeline stages; must divide WIDTH exactly
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  bundle accepted this cycle when in_valid is also high
//   a, b       in   operands [WIDTH-1:0]
//   c_in       in   carry into bit 0
//   sub        in   (PIPELINED_ADDER_SUB_EN only) compute a + ~b + 1
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   sum        out  result [WIDTH-1:0]
//   c_out      out  carry out of bit WIDTH-1
//   overflow   out  signed overflow (carry into MSB xor carry out of MSB)
//
// Optional feature macro: PIPELINED_ADDER_SUB_EN
//   Defined     -> adds the 'sub' input.
//   Not defined -> no 'sub' port, the block always adds.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int W = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  // Reject configurations that cannot be sliced evenly.
  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH exactly");
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the external carry is ignored in that mode.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  // ---------------------------------------------------------------------------
  // Stage registers. Operand skew registers carry the full width; the low
  // slices already consumed are never read and are pruned by synthesis.
  // ---------------------------------------------------------------------------
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic             ovf_q;

  // Per-stage combinational view of what enters each stage on an advance.
  logic             src_v   [STAGES];
  logic             src_cy  [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_res [STAGES];
  logic [W:0]       slice_add [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];

  logic adv;
  logic ovf_d;

  // The whole pipe moves together whenever the output slot is free or is
  // being drained this cycle.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_src
      assign src_v[gi]   = in_valid & adv;
      assign src_cy[gi]  = cin_eff;
      assign src_a[gi]   = a;
      assign src_b[gi]   = b_eff;
      assign src_res[gi] = '0;
    end else begin : g_src
      assign src_v[gi]   = vld_q[gi-1];
      assign src_cy[gi]  = cy_q[gi-1];
      assign src_a[gi]   = opa_q[gi-1];
      assign src_b[gi]   = opb_q[gi-1];
      assign src_res[gi] = res_q[gi-1];
    end

    // One W-bit slice plus carry; bit W is the carry into the next slice.
    assign slice_add[gi] = {1'b0, src_a[gi][gi*W +: W]}
                         + {1'b0, src_b[gi][gi*W +: W]}
                         + (W+1)'(src_cy[gi]);

    // Slices above the current one are still zero in src_res, so the new
    // slice can be merged with a plain OR.
    assign res_d[gi] = src_res[gi] | (WIDTH'(slice_add[gi][W-1:0]) << (gi*W));
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign ovf_d = slice_add[STAGES-1][W]
               ^ (slice_add[STAGES-1][W-1]
                  ^ src_a[STAGES-1][WIDTH-1]
                  ^ src_b[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= src_v[k];
        // Data only loads for real operations, so a bubble reaching the
        // output leaves the last result on sum/c_out/overflow.
        if (src_v[k]) begin
          res_q[k] <= res_d[k];
          cy_q[k]  <= slice_add[k][W];
          opa_q[k] <= src_a[k];
          opb_q[k] <= src_b[k];
        end
      end
      if (src_v[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign c_out     = cy_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised multi-stage ripple-carry adder, the successor to the single-bit full-adder cells. It splits a WIDTH-bit add into STAGES equal carry-chained slices, with one register stage per slice. Operands enter through a valid/ready input interface and results leave through a valid/ready output interface with full backpressure. It is the datapath adder for wider arithmetic blocks that need a registered, throttleable result.

Parameters:
WIDTH, 8, operand and sum width in bits; must be at least 1.
STAGES, 2, number of pipeline stages and equal slices; must divide WIDTH exactly, and elaboration fails otherwise.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand bundle valid.
in_ready  output  1  block can accept an operand bundle this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry into bit 0.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result bits.
c_out  output  1  carry out of bit WIDTH-1.
overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Interface: one clock domain; reset asynchronous and active-low. Asserting rst_n low immediately clears every stage valid flag and drives out_valid, sum, c_out and overflow to 0.
- Reset mid-operation: all in-flight operations are discarded. After release, in_ready=1 and out_valid=0.
- Slice width: W = WIDTH/STAGES. Stage k (0..STAGES-1) adds a[k*W +: W] + b[k*W +: W] + carry, where carry is c_in for k=0 and stage k-1's registered carry otherwise.
- Registered state per stage: valid bit, result slices computed so far, carry, and the not-yet-consumed upper operand slices (skew registers).
- Last stage registers: sum, c_out, overflow.
- Global advance enable: adv = !out_valid | out_ready. When adv=1, every stage shifts forward by one. When adv=0, all stage registers hold.
- in_ready = adv, a combinational function of out_valid and out_ready only.
- Transfer: an input transfer occurs when in_valid & in_ready. On an advance cycle with no transfer, a bubble (valid=0) enters stage 0.
- Latency: an operand accepted at rising edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages. With STAGES=1 the result is registered after one edge.
- Throughput: one result per cycle while out_ready=1. Bubbles are not collapsed; a bubble occupies its slot.
- Backpressure: while out_valid=1 and out_ready=0, sum/c_out/overflow are held stable, in_ready=0, and no data is lost or reordered.
- Ordering: strict FIFO order, with no internal state machine beyond the valid shift chain.
- When out_valid=0, sum/c_out/overflow hold their last values (0 after reset).
- Arithmetic: unsigned modulo 2^WIDTH; c_out is bit WIDTH of a+b+c_in. Overflow is computed on the MSB slice only.

Optional Feature:
Macro PIPELINED_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with the operands. When sub=1, the adder computes a + ~b + 1: b is inverted and carry-in is forced to 1, with c_in ignored. c_out=1 means no borrow, and overflow is signed subtraction overflow. When sub=0, behaviour is identical to the non-macro build.
- Not defined: no sub port exists, and the block always adds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs and in_valid=1 -> out_valid=0, sum=0, c_out=0, overflow=0; after release in_ready=1. Assert rst_n low again with 2 operations in flight -> out_valid drops immediately and neither result ever appears.
- Carry across slice boundary (WIDTH=8, STAGES=2): a=8'hFF, b=8'h01, c_in=0 -> out_valid exactly 2 cycles after acceptance, sum=8'h00, c_out=1, overflow=0. Then a=8'h0F, b=8'h00, c_in=1 -> sum=8'h10, c_out=0.
- Signed overflow: a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, overflow=1. Then a=8'h80, b=8'h80 -> sum=8'h00, c_out=1, overflow=1.
- Streaming: 4 back-to-back operations (1+2, 3+4, 200+100, 255+255) with out_ready=1 -> results 3, 7, 44 (c_out=1), 254 (c_out=1) on 4 consecutive cycles, in order.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> sum held constant, in_ready=0, and in_valid operands are not accepted. After out_ready=1, all queued results emerge in order with none lost or duplicated.
- SUB_EN build: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, c_out=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, c_out=1, overflow=1.
